enclave_op_scheduler: RTL and testbench

- Wishbone-facing command sequencer for the LWE encrypt/decrypt datapath.
- Accepts opcodes from the management SoC into a 4-deep queue and drives the datapath through start, per-coefficient step and done phases.
- Captures the datapath result into a read-to-clear output register; reports status and raises an interrupt.
- Sits between the wrapper's Wishbone slave port and the datapath core.

---
 rtl/enclave_op_scheduler_if.sv | 24 ++
 rtl/enclave_op_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_enclave_op_scheduler.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/enclave_op_scheduler_if.sv
// Wishbone slave bundle between the wrapper and the op scheduler.
// Ports: cyc/stb/we/sel/adr/dat_i from master; ack/dat_o to master.
interface enclave_op_scheduler_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/enclave_op_scheduler.sv
// Command sequencer: Wishbone opcode queue driving the LWE datapath.
// Ports: wb clk/rst, Wishbone slave bundle, dp start/step/done, irq.
module enclave_op_scheduler #(
  parameter logic [31:0] OPCODE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] STATUS_ADDR      = 32'h3000_0004,
  parameter logic [31:0] OUTPUT_ADDR      = 32'h3000_0008,
  parameter int          DIMENSION        = 128,
  parameter int          DIM_WIDTH        = 8,
  parameter int          CIPHERTEXT_WIDTH = 32,
  parameter int          FIFO_DEPTH       = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  enclave_op_scheduler_if.slave       wbs,
  output logic                        dp_start_o,
  output logic [1:0]                  dp_op_o,
  output logic                        dp_step_o,
  output logic [DIM_WIDTH-1:0]        dp_idx_o,
  input  logic                        dp_step_ready_i,
  input  logic                        dp_done_i,
  input  logic [CIPHERTEXT_WIDTH-1:0] dp_result_i,
  output logic                        irq_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;

  logic [2:0]                  r_state;
  logic [1:0]                  r_op;
  logic                        r_start;
  logic [DIM_WIDTH-1:0]        r_idx;
  logic [2:0]                  r_fifo [FIFO_DEPTH];
  logic [PW-1:0]               r_wp;
  logic [PW-1:0]               r_rp;
  logic [CW-1:0]               r_cnt;
  logic [CIPHERTEXT_WIDTH-1:0] r_res;
  logic                        r_rv;
  logic                        r_fovf;
  logic                        r_ill;
  logic                        r_rovf;
  logic                        r_irq;
  logic                        r_ack;
  logic [31:0]                 r_dat;

  logic        w_acc;
  logic        w_wr;
  logic        w_rd;
  logic        w_op_wr;
  logic        w_abort;
  logic        w_out_rd;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf;
  logic [2:0]  w_head;
  logic        w_hs;
  logic        w_last;
  logic        w_cap;
  logic [31:0] w_status;
  logic [31:0] w_res_ext;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_acc   = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack;
  assign w_wr    = w_acc & wbs.wbs_we_i;
  assign w_rd    = w_acc & ~wbs.wbs_we_i;
  assign w_op_wr = w_wr & (wbs.wbs_adr_i == OPCODE_ADDR)
                 & wbs.wbs_sel_i[0];
  assign w_abort = w_wr & (wbs.wbs_adr_i == STATUS_ADDR)
                 & wbs.wbs_dat_i[31];
  assign w_out_rd = w_rd & (wbs.wbs_adr_i == OUTPUT_ADDR);

  assign w_full = (r_cnt == CW'(FIFO_DEPTH));
  assign w_head = r_fifo[r_rp];
  assign w_pop  = (r_state == S_IDLE) & (r_cnt != '0) & ~w_abort;
  // A pop frees a slot this cycle, so a full queue still accepts.
  assign w_push = w_op_wr & (~w_full | w_pop);
  assign w_ovf  = w_op_wr & w_full & ~w_pop;

  // Step request starts the cycle after the start pulse.
  assign w_hs   = (r_state == S_STEP) & ~r_start & dp_step_ready_i;
  assign w_last = (r_idx == DIM_WIDTH'(DIMENSION - 1));
  // Opcodes 2 and 3 produce a result; LOAD_KEY (1) does not.
  assign w_cap  = (r_state == S_WAIT) & dp_done_i & r_op[1];

  assign w_status = {21'd0, r_state, r_rovf, r_ill, r_fovf,
                     3'(r_cnt), r_rv, (r_state != S_IDLE)};

  always_comb begin
    w_res_ext = '0;
    w_res_ext[CIPHERTEXT_WIDTH-1:0] = r_res;
  end

  always_comb begin
    w_rdata = '0;
    if (wbs.wbs_adr_i == STATUS_ADDR) w_rdata = w_status;
    if (wbs.wbs_adr_i == OUTPUT_ADDR) w_rdata = w_res_ext;
  end

  assign w_unused = ^{wbs.wbs_sel_i[3:1],
                      wbs.wbs_dat_i[30:3]};

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_fifo[r_wp] <= wbs.wbs_dat_i[2:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_start <= 1'b0;
      r_idx   <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_rv    <= 1'b0;
      r_fovf  <= 1'b0;
      r_ill   <= 1'b0;
      r_rovf  <= 1'b0;
      r_irq   <= 1'b0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_ack   <= w_acc;
      r_dat   <= w_rd ? w_rdata : '0;
      r_start <= 1'b0;
      r_irq   <= r_rv | r_fovf | r_ill | r_rovf;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_wp    <= '0;
        r_rp    <= '0;
        r_cnt   <= '0;
        r_fovf  <= 1'b0;
        r_ill   <= 1'b0;
        r_rovf  <= 1'b0;
      end else begin
        if (w_push) r_wp <= r_wp + PW'(1);
        if (w_pop)  r_rp <= r_rp + PW'(1);
        if (w_push & ~w_pop)
          r_cnt <= r_cnt + CW'(1);
        else if (w_pop & ~w_push)
          r_cnt <= r_cnt - CW'(1);
        if (w_ovf) r_fovf <= 1'b1;

        unique case (r_state)
          S_IDLE: begin
            if (w_pop) begin
              if (w_head[2]) begin
                r_ill <= 1'b1;
              end else if (w_head != 3'd0) begin
                r_op    <= w_head[1:0];
                r_state <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            r_start <= 1'b1;
            r_idx   <= '0;
            r_state <= S_STEP;
          end
          S_STEP: begin
            if (w_hs) begin
              if (w_last) r_state <= S_WAIT;
              else        r_idx <= r_idx + DIM_WIDTH'(1);
            end
          end
          S_WAIT: begin
            if (dp_done_i) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase

        // Capture beats a same-cycle read-clear and is not an overrun.
        if (w_cap) begin
          r_res <= dp_result_i;
          r_rv  <= 1'b1;
          if (r_rv & ~w_out_rd) r_rovf <= 1'b1;
        end else if (w_out_rd) begin
          r_rv <= 1'b0;
        end
      end
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign dp_start_o    = r_start;
  assign dp_op_o       = r_op;
  assign dp_step_o     = (r_state == S_STEP) & ~r_start;
  assign dp_idx_o      = r_idx;
  assign irq_o         = r_irq;

endmodule

// File: tb/tb_enclave_op_scheduler.sv
// Directed bench for enclave_op_scheduler.
// Drives Wishbone and a datapath stub; checks status and dp outputs.
module tb_enclave_op_scheduler;
  localparam logic [31:0] A_OPC = 32'h3000_0000;
  localparam logic [31:0] A_STS = 32'h3000_0004;
  localparam logic [31:0] A_OUT = 32'h3000_0008;
  localparam logic [31:0] A_BAD = 32'h3000_000C;
  localparam int DIM = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic        done = 1'b0;
  logic [31:0] result = '0;
  logic        start;
  logic [1:0]  op;
  logic        step;
  logic [7:0]  idx;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int starts = 0;
  int steps = 0;
  int exp_idx = 0;
  int idx_err = 0;
  int start_cyc = 0;
  int ack_cyc = 0;

  enclave_op_scheduler_if bus ();

  enclave_op_scheduler dut (
    .wb_clk_i        (clk),
    .wb_rst_ni       (rst_n),
    .wbs             (bus),
    .dp_start_o      (start),
    .dp_op_o         (op),
    .dp_step_o       (step),
    .dp_idx_o        (idx),
    .dp_step_ready_i (ready),
    .dp_done_i       (done),
    .dp_result_i     (result),
    .irq_o           (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n = cyc_n + 1;

  always @(negedge clk) begin
    if (start) begin
      starts    = starts + 1;
      start_cyc = cyc_n;
      exp_idx   = 0;
    end
    if (step && ready) begin
      if (int'(idx) != exp_idx) idx_err = idx_err + 1;
      exp_idx = exp_idx + 1;
      steps   = steps + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic we,
                         input logic [31:0] adr,
                         input logic [31:0] wd,
                         input logic [3:0] sel,
                         output logic [31:0] rd);
    logic got;
    got = 1'b0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wd;
    bus.wbs_sel_i = sel;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    rd      = bus.wbs_dat_o;
    ack_cyc = cyc_n;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    chk("wb_ack", 64'(got), 64'd1);
  endtask

  task automatic wr(input logic [31:0] adr,
                    input logic [31:0] d);
    logic [31:0] rd;
    wb_xfer(1'b1, adr, d, 4'hF, rd);
  endtask

  task automatic rdc(input string tag,
                     input logic [31:0] adr,
                     input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, adr, 32'd0, 4'hF, rd);
    chk(tag, 64'(rd), 64'(exp));
  endtask

  // Wait for op number `target` to finish all steps, then return done.
  task automatic do_op(input int target,
                       input logic [31:0] res);
    for (int k = 0; k < 1000; k++) begin
      if (starts >= target && exp_idx == DIM) break;
      tick(1);
    end
    chk("op_started", 64'(starts >= target), 64'd1);
    chk("op_steps", 64'(exp_idx), 64'(DIM));
    chk("op_idx_seq", 64'(idx_err), 64'd0);
    done   = 1'b1;
    result = res;
    tick(1);
    done   = 1'b0;
    result = '0;
  endtask

  initial begin
    int s0;
    int st0;
    logic [31:0] rd;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset while stepping
    wr(A_OPC, 32'd2);
    tick(4);
    chk("pre_rst_step", 64'(step), 64'd1);
    rst_n = 1'b0;
    tick(1);
    chk("rst_outs",
        64'({start, op, step, idx, irq,
             bus.wbs_ack_o, bus.wbs_dat_o}), 64'd0);
    rst_n = 1'b1;
    tick(1);
    rdc("rst_status", A_STS, 32'd0);

    // Single ENCRYPT, ready tied high
    ready = 1'b1;
    s0  = starts;
    st0 = steps;
    wr(A_OPC, 32'd2);
    do_op(s0 + 1, 32'h0000_03A5);
    chk("enc_starts", 64'(starts - s0), 64'd1);
    chk("enc_nsteps", 64'(steps - st0), 64'(DIM));
    chk("enc_latency", 64'(start_cyc - ack_cyc), 64'd2);
    tick(2);
    rdc("enc_status", A_STS, 32'h0000_0002);
    chk("enc_irq", 64'(irq), 64'd1);
    rdc("enc_out", A_OUT, 32'h0000_03A5);
    rdc("enc_clr_status", A_STS, 32'd0);
    tick(1);
    chk("enc_irq_clr", 64'(irq), 64'd0);

    // DECRYPT with a 5-cycle stall at idx 17
    s0  = starts;
    st0 = steps;
    wr(A_OPC, 32'd3);
    for (int k = 0; k < 100; k++) begin
      if (steps - st0 == 17) break;
      tick(1);
    end
    chk("stall_reach", 64'(steps - st0), 64'd17);
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("stall_step", 64'(step), 64'd1);
      chk("stall_idx", 64'(idx), 64'd17);
    end
    chk("stall_op", 64'(op), 64'd3);
    ready = 1'b1;
    do_op(s0 + 1, 32'h0000_1234);
    chk("stall_nsteps", 64'(steps - st0), 64'(DIM));
    tick(2);
    rdc("stall_out", A_OUT, 32'h0000_1234);

    // Queue overflow, illegal op, LOAD_KEY
    ready = 1'b0;
    s0 = starts;
    wr(A_OPC, 32'd2);
    tick(3);
    wr(A_OPC, 32'd1);
    wr(A_OPC, 32'd3);
    wr(A_OPC, 32'd0);
    wr(A_OPC, 32'd7);
    wr(A_OPC, 32'd2);
    rdc("q_status", A_STS, 32'h0000_0231);
    ready = 1'b1;
    do_op(s0 + 1, 32'h1111_0001);
    tick(2);
    rdc("q_out_a", A_OUT, 32'h1111_0001);
    do_op(s0 + 2, 32'h0000_BBBB);
    tick(2);
    wb_xfer(1'b0, A_STS, 32'd0, 4'hF, rd);
    chk("lk_no_cap", 64'(rd[1]), 64'd0);
    do_op(s0 + 3, 32'h0000_C0DE);
    tick(6);
    rdc("q_drain_status", A_STS, 32'h0000_0062);
    chk("q_starts", 64'(starts - s0), 64'd3);
    rdc("q_out_c", A_OUT, 32'h0000_C0DE);

    // Two ENCRYPTs, no read between
    s0 = starts;
    wr(A_OPC, 32'd2);
    wr(A_OPC, 32'd2);
    do_op(s0 + 1, 32'h0000_0A01);
    do_op(s0 + 2, 32'hDEAD_BEEF);
    tick(3);
    rdc("ovf_status", A_STS, 32'h0000_00E2);
    chk("ovf_irq", 64'(irq), 64'd1);
    rdc("ovf_out", A_OUT, 32'hDEAD_BEEF);

    // Soft abort mid-STEP with 3 queued
    ready = 1'b0;
    s0 = starts;
    wr(A_OPC, 32'd2);
    tick(3);
    wr(A_OPC, 32'd1);
    wr(A_OPC, 32'd2);
    wr(A_OPC, 32'd3);
    rdc("ab_pre_status", A_STS, 32'h0000_02ED);
    wr(A_STS, 32'h8000_0000);
    chk("ab_step", 64'(step), 64'd0);
    rdc("ab_status", A_STS, 32'd0);
    tick(1);
    chk("ab_irq", 64'(irq), 64'd0);
    ready = 1'b1;
    tick(20);
    chk("ab_no_start", 64'(starts - s0), 64'd1);

    // Opcode write without byte lane 0 is ignored
    wb_xfer(1'b1, A_OPC, 32'd2, 4'hE, rd);
    tick(5);
    chk("sel_ignored", 64'(starts - s0), 64'd1);
    rdc("unmapped_rd", A_BAD, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
